uart_tx_fifo: RTL

Transmit-side byte FIFO for the UART. It is written by the APB register interface and drained by the asynchronous transmitter, one byte per read strobe. It buffers outgoing characters so software can queue a burst without polling the transmitter. It sits directly upstream of the transmitter and supplies its data byte and empty flag.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo_if.sv | 32 +++
 rtl/uart_fifo_ram.sv | 31 +++
 rtl/uart_tx_fifo.sv | 82 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive FIFOs.
// The flag struct keeps empty/full/afull together as one registered group.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef struct packed {
    logic empty;
    logic full;
    logic afull;
  } fifo_flags_t;

  // Occupancy counter width: must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-FIFO bus between the APB writer/transmitter reader (master) and the FIFO (slave).
// Overflow signals exist only when UART_TX_FIFO_OVF_EN is defined.
interface uart_tx_fifo_if #(parameter int DEPTH = 16);
  import uart_pkg::*;

  localparam int CW = cnt_width(DEPTH);

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   rd_n;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   empty;
  logic                   full;
  logic                   afull;
  logic [CW-1:0]          count;

`ifdef UART_TX_FIFO_OVF_EN
  logic clr_ovf;
  logic overflow;

  modport master (output wr_en, wr_data, rd_n, clr_ovf,
                  input  rd_data, empty, full, afull, count, overflow);
  modport slave  (input  wr_en, wr_data, rd_n, clr_ovf,
                  output rd_data, empty, full, afull, count, overflow);
`else
  modport master (output wr_en, wr_data, rd_n,
                  input  rd_data, empty, full, afull, count);
  modport slave  (input  wr_en, wr_data, rd_n,
                  output rd_data, empty, full, afull, count);
`endif

endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 storage, one synchronous write port and one registered read port; read data
// appears one edge after re, holds otherwise. Array is unreset; only the read register resets.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic                   re,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-address read and write (only when full) returns the old entry.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: flags/count update on the accepting edge, rd_data registered; a write
// while full is dropped unless a read frees the slot that cycle. UART_TX_FIFO_OVF_EN adds a sticky overflow flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_nxt;
  fifo_flags_t            flags;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [UART_DATA_W-1:0] rd_data;

  assign rd_acc = !bus.rd_n && !flags.empty;
  assign wr_acc = bus.wr_en && (!flags.full || rd_acc);

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CW'(1);
    else if (!wr_acc && rd_acc) count_nxt = count - CW'(1);
  end

  // Flags are registered from the next count so they always agree with count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      flags <= '{empty: 1'b1, full: 1'b0, afull: 1'b0};
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      count       <= count_nxt;
      flags.empty <= (count_nxt == '0);
      flags.full  <= (count_nxt == CW'(DEPTH));
      flags.afull <= (count_nxt >= CW'(AFULL_LVL));
    end
  end

  uart_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc && !reset),
    .waddr (wptr),
    .wdata (bus.wr_data),
    .re    (rd_acc && !reset),
    .raddr (rptr),
    .rdata (rd_data)
  );

`ifdef UART_TX_FIFO_OVF_EN
  logic overflow;

  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge clk) begin
    if (reset)                                      overflow <= 1'b0;
    else if (bus.wr_en && flags.full && !rd_acc)    overflow <= 1'b1;
    else if (bus.clr_ovf)                           overflow <= 1'b0;
  end

  assign bus.overflow = overflow;
`endif

  assign bus.rd_data = rd_data;
  assign bus.count   = count;
  assign bus.empty   = flags.empty;
  assign bus.full    = flags.full;
  assign bus.afull   = flags.afull;

endmodule
